simt_reconv_stack: RTL and testbench

SIMT_RECONV_STACK -- requirements
Module: simt_reconv_stack

---
 rtl/cpu_types_pkg.sv | 11 +
 rtl/simt_reconv_stack_if.sv | 44 ++++
 rtl/simt_reconv_stack.sv | 129 ++++++++++++
 tb/tb_simt_reconv_stack.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: PC word type and the default SIMT lane count.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int SIMT_THREADS = 4;

  // Reset value of the current reconvergence PC: "no reconvergence point".
  localparam word_t RPC_NONE_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/simt_reconv_stack_if.sv
// Branch / fetch / redirect bundle between the SIMT front end and the
// reconvergence stack. master = front end, slave = stack.
interface simt_reconv_stack_if
  import cpu_types_pkg::*;
#(
  parameter int THREADS = SIMT_THREADS,
  parameter int DEPTH   = 8
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               stall;
  logic               br_valid;
  logic [THREADS-1:0] br_taken;
  word_t              br_target;
  word_t              br_fallthru;
  word_t              br_reconv;
  logic               fetch_valid;
  word_t              fetch_pc;

  logic [THREADS-1:0] mask_out;
  logic               redirect_valid;
  word_t              redirect_pc;
  logic               br_ready;
  logic [CNT_W-1:0]   depth_cnt;
  logic               full;
  logic               empty;
  logic               overflow;

  modport master (
    output stall, br_valid, br_taken, br_target, br_fallthru, br_reconv,
           fetch_valid, fetch_pc,
    input  mask_out, redirect_valid, redirect_pc, br_ready, depth_cnt,
           full, empty, overflow
  );

  modport slave (
    input  stall, br_valid, br_taken, br_target, br_fallthru, br_reconv,
           fetch_valid, fetch_pc,
    output mask_out, redirect_valid, redirect_pc, br_ready, depth_cnt,
           full, empty, overflow
  );

endinterface

// File: rtl/simt_reconv_stack.sv
// SIMT reconvergence stack: tracks the active lane mask across divergent
// branches and replays the deferred paths when fetch reaches the
// reconvergence PC. A divergent branch pushes two entries (the join entry
// and the not-taken path); each arrival at the current reconvergence PC
// pops one entry.
module simt_reconv_stack
  import cpu_types_pkg::*;
#(
  parameter int    THREADS  = SIMT_THREADS,
  parameter int    DEPTH    = 8,
  parameter word_t RPC_NONE = RPC_NONE_DEFAULT
) (
  input logic                CLK,
  input logic                nRST,
  simt_reconv_stack_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    word_t              pc;
    logic [THREADS-1:0] mask;
    word_t              rpc;
  } entry_t;

  // Stack storage; only entries below depth_q are meaningful, so no reset.
  entry_t             stack_q [DEPTH];

  logic [THREADS-1:0] cur_mask_q;
  word_t              cur_rpc_q;
  logic [CNT_W-1:0]   depth_q;
  logic               ovf_q;
  logic               redir_vld_q;
  word_t              redir_pc_q;

  logic               empty;
  logic               full;
  logic               pop_hit;
  logic               do_pop;
  logic               ready;
  logic               accept;
  logic [THREADS-1:0] act;
  logic               uni_taken;
  logic               uni_ntaken;
  logic               diverge;
  logic               do_push;
  logic               do_ovf;
  logic [IDX_W-1:0]   top_idx;
  logic [IDX_W-1:0]   push_idx0;
  logic [IDX_W-1:0]   push_idx1;
  entry_t             top_e;

  assign empty      = (depth_q == '0);
  // Full means a divergent branch could not fit its two entries.
  assign full       = (depth_q > CNT_W'(DEPTH - 2));

  // Reaching the reconvergence PC outranks a pending branch.
  assign pop_hit    = bus.fetch_valid & ~empty & (bus.fetch_pc == cur_rpc_q);
  assign do_pop     = pop_hit & ~bus.stall;
  assign ready      = ~pop_hit & ~bus.stall;
  assign accept     = bus.br_valid & ready;

  assign act        = cur_mask_q & bus.br_taken;
  assign uni_taken  = accept & (act == cur_mask_q);
  assign uni_ntaken = (act == '0);
  assign diverge    = accept & ~uni_taken & ~uni_ntaken;
  assign do_push    = diverge & ~full;
  assign do_ovf     = diverge & full;

  assign top_idx    = IDX_W'(depth_q - CNT_W'(1));
  assign push_idx0  = IDX_W'(depth_q);
  assign push_idx1  = IDX_W'(depth_q + CNT_W'(1));
  assign top_e      = stack_q[top_idx];

  // Control state: current mask/rpc, occupancy, sticky overflow, redirect pulse.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cur_mask_q  <= '1;
      cur_rpc_q   <= RPC_NONE;
      depth_q     <= '0;
      ovf_q       <= 1'b0;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
    end else begin
      redir_vld_q <= 1'b0;
      if (!bus.stall) begin
        if (do_pop) begin
          cur_mask_q  <= top_e.mask;
          cur_rpc_q   <= top_e.rpc;
          depth_q     <= depth_q - CNT_W'(1);
          redir_vld_q <= 1'b1;
          redir_pc_q  <= top_e.pc;
        end else if (do_push) begin
          cur_mask_q  <= act;
          cur_rpc_q   <= bus.br_reconv;
          depth_q     <= depth_q + CNT_W'(2);
          redir_vld_q <= 1'b1;
          redir_pc_q  <= bus.br_target;
        end else if (uni_taken) begin
          redir_vld_q <= 1'b1;
          redir_pc_q  <= bus.br_target;
        end
        if (do_ovf) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  // Divergence push: join entry below, deferred not-taken path on top.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      stack_q[push_idx0] <= '{pc: bus.br_reconv, mask: cur_mask_q, rpc: cur_rpc_q};
      stack_q[push_idx1] <= '{pc: bus.br_fallthru, mask: cur_mask_q & ~bus.br_taken,
                              rpc: bus.br_reconv};
    end
  end

  assign bus.mask_out       = cur_mask_q;
  assign bus.redirect_valid = redir_vld_q;
  assign bus.redirect_pc    = redir_pc_q;
  assign bus.br_ready       = ready;
  assign bus.depth_cnt      = depth_q;
  assign bus.full           = full;
  assign bus.empty          = empty;
  assign bus.overflow       = ovf_q;

endmodule

// File: tb/tb_simt_reconv_stack.sv
// Bench for simt_reconv_stack: directed scenarios plus randomized traffic
// against a queue-based reference model; an 8-lane instance covers overflow.
module tb_simt_reconv_stack;
  import cpu_types_pkg::*;

  localparam int    D    = 8;
  localparam word_t NONE = 32'hFFFF_FFFF;

  logic CLK = 1'b0;
  logic nRST;

  always #5 CLK = ~CLK;

  simt_reconv_stack_if #(.THREADS(4), .DEPTH(D)) bus ();
  simt_reconv_stack_if #(.THREADS(8), .DEPTH(D)) bus8 ();

  simt_reconv_stack #(.THREADS(4), .DEPTH(D), .RPC_NONE(NONE)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus.slave)
  );

  simt_reconv_stack #(.THREADS(8), .DEPTH(D), .RPC_NONE(NONE)) dut8 (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus8.slave)
  );

  typedef struct {
    word_t      pc;
    logic [3:0] mask;
    word_t      rpc;
  } ment_t;

  ment_t      mstk[$];
  logic [3:0] m_mask;
  word_t      m_rpc;
  bit         m_ovf;
  bit         m_rv;
  word_t      m_rpo;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mstk.delete();
    m_mask = 4'hF;
    m_rpc  = NONE;
    m_ovf  = 1'b0;
    m_rv   = 1'b0;
    m_rpo  = '0;
  endtask

  // One clock of stimulus: check br_ready before the edge, advance the model,
  // then compare every registered output after the edge.
  task automatic step(input string tag);
    bit         hit;
    logic [3:0] a;
    ment_t      e;
    #1;
    hit = bus.fetch_valid && (mstk.size() > 0) && (bus.fetch_pc == m_rpc);
    chk({tag, ".br_ready"}, 64'(bus.br_ready), 64'(!hit && !bus.stall));
    m_rv = 1'b0;
    if (!bus.stall) begin
      if (hit) begin
        e      = mstk.pop_back();
        m_mask = e.mask;
        m_rpc  = e.rpc;
        m_rv   = 1'b1;
        m_rpo  = e.pc;
      end else if (bus.br_valid) begin
        a = m_mask & bus.br_taken;
        if (a == m_mask) begin
          m_rv  = 1'b1;
          m_rpo = bus.br_target;
        end else if (a != 4'h0) begin
          if (D - mstk.size() < 2) begin
            m_ovf = 1'b1;
          end else begin
            mstk.push_back('{pc: bus.br_reconv, mask: m_mask, rpc: m_rpc});
            mstk.push_back('{pc: bus.br_fallthru, mask: m_mask & ~bus.br_taken,
                             rpc: bus.br_reconv});
            m_mask = a;
            m_rpc  = bus.br_reconv;
            m_rv   = 1'b1;
            m_rpo  = bus.br_target;
          end
        end
      end
    end
    @(posedge CLK);
    #1;
    chk({tag, ".mask_out"},       64'(bus.mask_out),       64'(m_mask));
    chk({tag, ".redirect_valid"}, 64'(bus.redirect_valid), 64'(m_rv));
    if (m_rv) chk({tag, ".redirect_pc"}, 64'(bus.redirect_pc), 64'(m_rpo));
    chk({tag, ".depth_cnt"},      64'(bus.depth_cnt),      64'(mstk.size()));
    chk({tag, ".empty"},          64'(bus.empty),          64'(mstk.size() == 0));
    chk({tag, ".full"},           64'(bus.full),           64'(D - mstk.size() < 2));
    chk({tag, ".overflow"},       64'(bus.overflow),       64'(m_ovf));
  endtask

  task automatic set_br(input bit v, input logic [3:0] tk, input word_t tgt,
                        input word_t ft, input word_t rc);
    bus.br_valid    = v;
    bus.br_taken    = tk;
    bus.br_target   = tgt;
    bus.br_fallthru = ft;
    bus.br_reconv   = rc;
  endtask

  task automatic set_fetch(input bit v, input word_t pc);
    bus.fetch_valid = v;
    bus.fetch_pc    = pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  snap_mask;
    logic [3:0]  snap_depth;
    word_t       snap_rpc;
    logic [7:0]  all8;

    all8 = 8'hFF;
    bus.stall = 1'b0;
    set_br(1'b0, 4'h0, '0, '0, '0);
    set_fetch(1'b0, '0);
    bus8.stall       = 1'b0;
    bus8.br_valid    = 1'b0;
    bus8.br_taken    = '0;
    bus8.br_target   = '0;
    bus8.br_fallthru = '0;
    bus8.br_reconv   = '0;
    bus8.fetch_valid = 1'b0;
    bus8.fetch_pc    = '0;
    model_reset();

    // Reset values
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst.mask_out",       64'(bus.mask_out),       64'(4'b1111));
    chk("rst.empty",          64'(bus.empty),          64'(1));
    chk("rst.full",           64'(bus.full),           64'(0));
    chk("rst.depth_cnt",      64'(bus.depth_cnt),      64'(0));
    chk("rst.overflow",       64'(bus.overflow),       64'(0));
    chk("rst.redirect_valid", 64'(bus.redirect_valid), 64'(0));
    chk("rst.redirect_pc",    64'(bus.redirect_pc),    64'(0));
    chk("rst.br_ready",       64'(bus.br_ready),       64'(1));
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Divergence and two reconvergence pops
    set_br(1'b1, 4'b0011, 32'h100, 32'h40, 32'h80);
    step("div");
    chk("div.mask",  64'(bus.mask_out),    64'(4'b0011));
    chk("div.rpc",   64'(bus.redirect_pc), 64'(32'h100));
    chk("div.depth", 64'(bus.depth_cnt),   64'(2));
    set_br(1'b0, 4'h0, '0, '0, '0);
    set_fetch(1'b1, 32'h80);
    step("pop1");
    chk("pop1.mask", 64'(bus.mask_out),    64'(4'b1100));
    chk("pop1.rpc",  64'(bus.redirect_pc), 64'(32'h40));
    step("pop2");
    chk("pop2.mask",  64'(bus.mask_out),    64'(4'b1111));
    chk("pop2.rpc",   64'(bus.redirect_pc), 64'(32'h80));
    chk("pop2.empty", 64'(bus.empty),       64'(1));
    step("empty_ign");
    chk("empty_ign.rv", 64'(bus.redirect_valid), 64'(0));

    // Uniform taken / not-taken
    set_fetch(1'b0, '0);
    set_br(1'b1, 4'b1111, 32'h100, 32'h44, 32'h90);
    step("uni_t");
    chk("uni_t.rv",    64'(bus.redirect_valid), 64'(1));
    chk("uni_t.rpc",   64'(bus.redirect_pc),    64'(32'h100));
    chk("uni_t.depth", 64'(bus.depth_cnt),      64'(0));
    set_br(1'b1, 4'b0000, 32'h100, 32'h44, 32'h90);
    step("uni_nt");
    chk("uni_nt.rv",   64'(bus.redirect_valid), 64'(0));
    chk("uni_nt.mask", 64'(bus.mask_out),       64'(4'b1111));

    // Pop outranks a simultaneous branch; branch lands next cycle
    set_br(1'b1, 4'b0011, 32'h100, 32'h40, 32'h80);
    step("div2");
    set_br(1'b1, 4'b0100, 32'h200, 32'h204, 32'h300);
    set_fetch(1'b1, 32'h80);
    #1;
    chk("prio.br_ready_pre", 64'(bus.br_ready), 64'(0));
    step("prio");
    chk("prio.mask",  64'(bus.mask_out),    64'(4'b1100));
    chk("prio.rpc",   64'(bus.redirect_pc), 64'(32'h40));
    chk("prio.depth", 64'(bus.depth_cnt),   64'(1));
    set_fetch(1'b0, '0);
    step("late_br");
    chk("late_br.mask",  64'(bus.mask_out),    64'(4'b0100));
    chk("late_br.rpc",   64'(bus.redirect_pc), 64'(32'h200));
    chk("late_br.depth", 64'(bus.depth_cnt),   64'(3));

    // Stall right after an event: pulse drops, then everything frozen
    set_br(1'b1, 4'b1111, 32'h500, 32'h504, 32'h508);
    set_fetch(1'b1, 32'h300);
    bus.stall = 1'b1;
    step("stall_pulse");
    snap_mask  = bus.mask_out;
    snap_depth = bus.depth_cnt;
    snap_rpc   = bus.redirect_pc;
    for (int k = 0; k < 3; k++) begin
      step("stall");
      chk("stall.mask",  64'(bus.mask_out),       64'(snap_mask));
      chk("stall.depth", 64'(bus.depth_cnt),      64'(snap_depth));
      chk("stall.rpc",   64'(bus.redirect_pc),    64'(snap_rpc));
      chk("stall.rv",    64'(bus.redirect_valid), 64'(0));
    end
    bus.stall = 1'b0;
    set_br(1'b0, 4'h0, '0, '0, '0);
    set_fetch(1'b0, '0);

    // Asynchronous reset mid-divergence
    #2;
    nRST = 1'b0;
    #1;
    chk("arst1.depth", 64'(bus.depth_cnt), 64'(0));
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    set_br(1'b1, 4'b0011, 32'h100, 32'h40, 32'h80);
    step("d4a");
    set_br(1'b1, 4'b0001, 32'h180, 32'h140, 32'h160);
    step("d4b");
    chk("d4b.depth", 64'(bus.depth_cnt), 64'(4));
    set_br(1'b0, 4'h0, '0, '0, '0);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst2.mask",  64'(bus.mask_out),  64'(4'b1111));
    chk("arst2.depth", 64'(bus.depth_cnt), 64'(0));
    chk("arst2.empty", 64'(bus.empty),     64'(1));
    chk("arst2.rv",    64'(bus.redirect_valid), 64'(0));
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus.stall = ($urandom_range(0, 9) == 0);
      set_br($urandom_range(0, 1) == 1, 4'($urandom),
             word_t'($urandom_range(1, 63)) << 2,
             word_t'($urandom_range(1, 63)) << 2,
             word_t'($urandom_range(64, 127)) << 2);
      set_fetch($urandom_range(0, 2) != 0,
                ($urandom_range(0, 1) == 1) ? m_rpc : (word_t'($urandom_range(64, 127)) << 2));
      step("rnd");
    end
    bus.stall = 1'b0;
    set_br(1'b0, 4'h0, '0, '0, '0);
    set_fetch(1'b0, '0);

    // 8-lane instance: fill to DEPTH, then one more divergence overflows
    bus8.br_valid = 1'b1;
    for (int i = 0; i < D / 2; i++) begin
      bus8.br_taken    = all8 >> (i + 1);
      bus8.br_target   = 32'h1000 + 32'(i * 16);
      bus8.br_fallthru = 32'h2000 + 32'(i * 16);
      bus8.br_reconv   = 32'h3000 + 32'(i * 16);
      @(posedge CLK);
      #1;
      chk("fill.depth", 64'(bus8.depth_cnt), 64'(2 * (i + 1)));
      chk("fill.mask",  64'(bus8.mask_out),  64'(all8 >> (i + 1)));
      chk("fill.rv",    64'(bus8.redirect_valid), 64'(1));
    end
    bus8.br_taken = 8'h07;
    @(posedge CLK);
    #1;
    chk("ovf.overflow", 64'(bus8.overflow),       64'(1));
    chk("ovf.rv",       64'(bus8.redirect_valid), 64'(0));
    chk("ovf.depth",    64'(bus8.depth_cnt),      64'(D));
    chk("ovf.mask",     64'(bus8.mask_out),       64'(8'h0F));
    chk("ovf.full",     64'(bus8.full),           64'(1));
    bus8.br_valid = 1'b0;
    @(posedge CLK);
    #1;
    chk("ovf.sticky",   64'(bus8.overflow),       64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
